lcd_message_streamer: RTL and testbench
=======================================

// Module: lcd_message_streamer
// PURPOSE
//  Parametrised successor to the static message table. Holds the display message set internally.
//  On request, streams a selected message as a byte sequence to the LCD character writer.
//  Each row is preceded by a DDRAM set-address command.
//  Uses a valid/ready handshake and a one-deep pending-request buffer.
//  Sits between the rain/bluetooth status FSM and the LCD interface driver.
// PARAMETERS
//  COLS         16  characters per row (1..40); text is truncated or space-padded to COLS
//  ROWS          2  display rows (1..4)
//  MSG_W         3  width of message selector
//  AUTO_UPDATE   1  1: a change of msg_sel while idle starts a frame; 0: only msg_load starts
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  msg_sel    in   MSG_W  message index
//  msg_load   in   1      1-cycle request to stream msg_sel
//  out_data   out  8      ASCII char or LCD command byte
//  out_is_cmd out  1      1: out_data is a command (RS=0); 0: character (RS=1)
//  out_valid  out  1      out_data/out_is_cmd valid
//  out_ready  in   1      downstream accepts beat when out_valid & out_ready
//  busy       out  1      frame in progress
//  done       out  1      1-cycle pulse after last beat of a frame is accepted
// BEHAVIOUR
//  - Reset: out_data=8'h00, out_is_cmd=0, out_valid=0, busy=0, done=0, state IDLE.
//    The pending buffer is cleared. last_sel is reset to 0.
//  - Message table (row0 / row1, space-padded):
//    0 blank; 1 "Chovendo !"; 2 "Tempo Seco !"; 3 "Bluetooth:"/"On"; 4 "Bluetooth:"/"Off";
//    5 "Sensor desligado"/"Bluetooth: Off"; 6 "Bluetooth:"/"Reset!".
//    Indices >=7 are blank. Rows >=2 are always blank. Blank = 8'h20.
//  - FSM states:
//    IDLE -> CMD on start.
//    CMD  -> CHAR on accept.
//    CHAR -> CHAR on accept while col<COLS-1.
//    CHAR -> CMD on accept at the last col of a non-final row.
//    CHAR -> DONE on accept at the last col of the final row.
//    DONE -> CMD if pending is set, else -> IDLE. DONE lasts one cycle.
//  - Start condition: msg_load, or (AUTO_UPDATE && msg_sel!=last_sel), sampled in IDLE.
//    Cycle N start -> cycle N+1: out_valid=1, first command beat. Index is latched at start.
//  - Command byte for row r: 8'h80 | addr, where addr = (r[0]?8'h40:8'h00) + (r[1]?COLS:0).
//    Example: row0 0x80, row1 0xC0.
//  - Frame = ROWS*(COLS+1) beats. The first beat of each row is the command, then COLS characters.
//  - Handshake:
//    - While out_valid & !out_ready, out_data and out_is_cmd hold stable and out_valid stays 1.
//    - A beat is accepted on the cycle both valid and ready are high.
//    - The next beat is presented in the following cycle, so full throughput is 1 beat/cycle.
//  - busy=1 from the cycle after start through the DONE cycle. done=1 only in the DONE cycle.
//    out_valid=0 in DONE and IDLE.
//  - Request while busy:
//    - The latest index is stored in the pending buffer, overwriting any earlier pending request.
//    - The in-flight frame is never altered or aborted.
//    - DONE then goes directly to CMD with the pending index, and pending is cleared.
//  - Request in the DONE cycle counts as pending. A simultaneous request in IDLE starts immediately.
//  - last_sel updates to the latched index at every frame start.
//  - Reset mid-frame: all outputs return to reset values asynchronously.
//    No partial frame is resumed after reset.
// TESTING
//  - Reset, msg_sel=1, msg_load pulse, out_ready=1
//    -> beats 0x80(cmd), 'C','h','o','v','e','n','d','o',' ','!', 6x 0x20;
//       then 0xC0(cmd), 16x 0x20; done in cycle 35 after load.
//  - msg_sel=3, out_ready toggling 1-0-1
//    -> data held while stalled; row1 stream is 0xC0, 'O','n', 14x 0x20; exactly 34 accepted beats.
//  - Pulse msg_load with sel=2, then sel=5 and sel=6 while busy
//    -> frame 2 completes intact; next frame streams 6 (last pending); sel 5 is never sent.
//  - AUTO_UPDATE=1, msg_sel changes 0->4 with no load
//    -> frame starts next cycle with 0x80; holding sel=4 afterwards starts no further frames.
//  - COLS=20, ROWS=4, sel=5
//    -> commands 0x80, 0xC0, 0x94, 0xD4; rows 2-3 all 0x20; 84 beats total.
//  - rst_n low at beat 10 of a frame
//    -> out_valid=0, busy=0 immediately; no beats after release until a new request.

Source files
------------

// File: rtl/lcd_message_streamer.sv
// ============================================================================
// lcd_message_streamer
// ----------------------------------------------------------------------------
// Holds the display message set internally and, on request, streams the
// selected message to the LCD character writer as a byte sequence. Every row
// is preceded by a DDRAM set-address command; text is truncated or padded
// with spaces to COLS characters.
//
// Ports
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous reset, active low
//   msg_sel     in   MSG_W  message index
//   msg_load    in   1      one-cycle request to stream msg_sel
//   out_data    out  8      ASCII character or LCD command byte
//   out_is_cmd  out  1      1: out_data is a command (RS=0), 0: character
//   out_valid   out  1      out_data/out_is_cmd valid
//   out_ready   in   1      downstream accepts a beat when valid & ready
//   busy        out  1      frame in progress (first beat through DONE)
//   done        out  1      one-cycle pulse after the last beat is accepted
// ============================================================================
module lcd_message_streamer #(
    parameter int unsigned COLS        = 16,  // 1..40
    parameter int unsigned ROWS        = 2,   // 1..4
    parameter int unsigned MSG_W       = 3,
    parameter bit          AUTO_UPDATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MSG_W-1:0] msg_sel,
    input  logic             msg_load,
    output logic [7:0]       out_data,
    output logic             out_is_cmd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_CHAR = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       row_q, row_d;        // up to 4 rows
    logic [5:0]       col_q, col_d;        // up to 40 columns
    logic [MSG_W-1:0] sel_q, sel_d;        // index latched at frame start
    logic [MSG_W-1:0] last_sel_q, last_sel_d;
    logic             pend_q, pend_d;
    logic [MSG_W-1:0] pend_sel_q, pend_sel_d;

    logic             start;
    logic [MSG_W-1:0] start_sel;

    // Character at (row, col) of message sel. Each stored line is 16 chars,
    // left-justified in a 128-bit word (first character in the top byte).
    function automatic logic [7:0] text_char(input logic [MSG_W-1:0] sel,
                                             input logic [1:0]       row,
                                             input logic [5:0]       col);
        logic [127:0] line;
        int unsigned  sel_n;
        sel_n = int'(sel);
        line  = {16{8'h20}};
        if (row == 2'd0) begin
            case (sel_n)
                1:       line = {"Chovendo !", {6{8'h20}}};
                2:       line = {"Tempo Seco !", {4{8'h20}}};
                3, 4, 6: line = {"Bluetooth:", {6{8'h20}}};
                5:       line = "Sensor desligado";
                default: line = {16{8'h20}};
            endcase
        end else if (row == 2'd1) begin
            case (sel_n)
                3:       line = {"On", {14{8'h20}}};
                4:       line = {"Off", {13{8'h20}}};
                5:       line = {"Bluetooth: Off", {2{8'h20}}};
                6:       line = {"Reset!", {10{8'h20}}};
                default: line = {16{8'h20}};
            endcase
        end
        // Columns beyond the stored text are padding.
        if (col < 6'd16) begin
            text_char = line[8*(15 - int'(col)) +: 8];
        end else begin
            text_char = 8'h20;
        end
    endfunction

    // DDRAM set-address: odd rows live at 0x40, rows 2/3 continue COLS
    // characters further on (4-line module layout).
    function automatic logic [7:0] cmd_byte(input logic [1:0] row);
        logic [7:0] addr;
        addr     = (row[0] ? 8'h40 : 8'h00) + (row[1] ? 8'(COLS) : 8'h00);
        cmd_byte = 8'h80 | addr;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            row_q      <= 2'd0;
            col_q      <= 6'd0;
            sel_q      <= '0;
            last_sel_q <= '0;
            pend_q     <= 1'b0;
            pend_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            sel_q      <= sel_d;
            last_sel_q <= last_sel_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        sel_d      = sel_q;
        last_sel_d = last_sel_q;
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
        out_data   = 8'h00;
        out_is_cmd = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        start      = 1'b0;
        start_sel  = msg_sel;

        case (state_q)
            ST_IDLE: begin
                // A fresh load beats a leftover pending request; either
                // way the pending slot is consumed by the start.
                if (msg_load) begin
                    start = 1'b1;
                end else if (pend_q) begin
                    start     = 1'b1;
                    start_sel = pend_sel_q;
                end else if (AUTO_UPDATE && (msg_sel != last_sel_q)) begin
                    start = 1'b1;
                end
                if (start) begin
                    pend_d = 1'b0;
                end
            end
            ST_CMD: begin
                out_valid  = 1'b1;
                out_is_cmd = 1'b1;
                out_data   = cmd_byte(row_q);
                busy       = 1'b1;
                if (out_ready) begin
                    state_d = ST_CHAR;
                    col_d   = 6'd0;
                end
            end
            ST_CHAR: begin
                out_valid = 1'b1;
                out_data  = text_char(sel_q, row_q, col_q);
                busy      = 1'b1;
                if (out_ready) begin
                    if (col_q == 6'(COLS - 1)) begin
                        col_d = 6'd0;
                        if (row_q == 2'(ROWS - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            row_d   = row_q + 2'd1;
                            state_d = ST_CMD;
                        end
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
                if (pend_q) begin
                    start     = 1'b1;
                    start_sel = pend_sel_q;
                    pend_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d    = ST_CMD;
            row_d      = 2'd0;
            col_d      = 6'd0;
            sel_d      = start_sel;
            last_sel_d = start_sel;
        end

        // Any load outside IDLE (including the DONE cycle) lands in the
        // one-deep buffer, newest request wins. Placed last so it survives
        // the clear above when DONE consumes an older pending request.
        if (msg_load && (state_q != ST_IDLE)) begin
            pend_d     = 1'b1;
            pend_sel_d = msg_sel;
        end
    end

endmodule

// File: tb/tb_lcd_message_streamer.sv
// Bench for lcd_message_streamer: stimulus tasks push expected beats into a
// queue per DUT instance, monitor processes pop and compare accepted beats.
module tb_lcd_message_streamer;

    logic       clk;
    logic       rst_n;
    logic [2:0] msg_sel;
    logic       msg_load;
    logic [7:0] out_data;
    logic       out_is_cmd;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    logic       rst4_n;
    logic [2:0] msg_sel4;
    logic       msg_load4;
    logic [7:0] out_data4;
    logic       out_is_cmd4;
    logic       out_valid4;
    logic       out_ready4;
    logic       busy4;
    logic       done4;

    int n_checks;
    int n_errors;
    int acc0;
    int acc4;
    bit toggle_en;

    logic [8:0] q0[$];
    logic [8:0] q4[$];

    lcd_message_streamer #(.COLS(16), .ROWS(2), .MSG_W(3), .AUTO_UPDATE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .msg_sel(msg_sel), .msg_load(msg_load),
        .out_data(out_data), .out_is_cmd(out_is_cmd), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    lcd_message_streamer #(.COLS(20), .ROWS(4), .MSG_W(3), .AUTO_UPDATE(1'b1)) dut4 (
        .clk(clk), .rst_n(rst4_n), .msg_sel(msg_sel4), .msg_load(msg_load4),
        .out_data(out_data4), .out_is_cmd(out_is_cmd4), .out_valid(out_valid4),
        .out_ready(out_ready4), .busy(busy4), .done(done4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic string row_text(input int sel, input int row);
        string s;
        s = "";
        if (row == 0) begin
            case (sel)
                1: s = "Chovendo !";
                2: s = "Tempo Seco !";
                3: s = "Bluetooth:";
                4: s = "Bluetooth:";
                5: s = "Sensor desligado";
                6: s = "Bluetooth:";
                default: s = "";
            endcase
        end else if (row == 1) begin
            case (sel)
                3: s = "On";
                4: s = "Off";
                5: s = "Bluetooth: Off";
                6: s = "Reset!";
                default: s = "";
            endcase
        end
        return s;
    endfunction

    task automatic push_frame(input int which, input int sel, input int cols, input int rows);
        string      txt;
        logic [7:0] addr;
        logic [8:0] beat;
        for (int r = 0; r < rows; r++) begin
            addr = 8'(((r % 2) != 0 ? 'h40 : 0) + ((r / 2) != 0 ? cols : 0));
            beat = {1'b1, 8'h80 | addr};
            if (which == 0) q0.push_back(beat); else q4.push_back(beat);
            txt = row_text(sel, r);
            for (int c = 0; c < cols; c++) begin
                beat = {1'b0, (c < txt.len()) ? txt[c] : 8'h20};
                if (which == 0) q0.push_back(beat); else q4.push_back(beat);
            end
        end
    endtask

    task automatic monitor0();
        logic [8:0] prev;
        logic [8:0] expv;
        logic       stall;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) chk("hold while stalled", {23'd0, out_valid, out_is_cmd, out_data}, {23'd0, 1'b1, prev});
                if (out_valid && out_ready) begin
                    acc0++;
                    if (q0.size() == 0) begin
                        chk("unexpected beat", {23'd0, out_is_cmd, out_data}, 32'hFFFF_FFFF);
                    end else begin
                        expv = q0.pop_front();
                        chk("beat", {23'd0, out_is_cmd, out_data}, {23'd0, expv});
                    end
                end
                stall = out_valid && !out_ready;
                prev  = {out_is_cmd, out_data};
            end
        end
    endtask

    task automatic monitor4();
        logic [8:0] expv;
        forever begin
            @(negedge clk);
            if (rst4_n && out_valid4 && out_ready4) begin
                acc4++;
                if (q4.size() == 0) begin
                    chk("unexpected beat dut4", {23'd0, out_is_cmd4, out_data4}, 32'hFFFF_FFFF);
                end else begin
                    expv = q4.pop_front();
                    chk("beat dut4", {23'd0, out_is_cmd4, out_data4}, {23'd0, expv});
                end
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) out_ready = ~out_ready;
            else out_ready = 1'b1;
        end
    endtask

    task automatic pulse_load(input logic [2:0] sel);
        @(posedge clk);
        #1;
        msg_sel  = sel;
        msg_load = 1'b1;
        @(posedge clk);
        #1;
        msg_load = 1'b0;
    endtask

    // Returns the negedge count (1 = first mid-cycle after the call) at which
    // done was seen, 0 on timeout.
    task automatic wait_done(output int k);
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (done) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k;
        int base;
        int busy_cnt;
        n_checks   = 0;
        n_errors   = 0;
        acc0       = 0;
        acc4       = 0;
        toggle_en  = 1'b0;
        rst_n      = 1'b0;
        rst4_n     = 1'b0;
        msg_sel    = 3'd0;
        msg_load   = 1'b0;
        out_ready  = 1'b1;
        msg_sel4   = 3'd0;
        msg_load4  = 1'b0;
        out_ready4 = 1'b1;

        fork
            monitor0();
            monitor4();
            ready_driver();
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset out_data", {24'd0, out_data}, 32'h00);
        chk("reset out_is_cmd", {31'd0, out_is_cmd}, 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rst4_n = 1'b1;

        // Frame for message 1 at full throughput
        push_frame(0, 1, 16, 2);
        pulse_load(3'd1);
        wait_done(k);
        chk("sel1 done cycle after load", k, 35);
        repeat (2) @(negedge clk);
        chk("sel1 queue drained", q0.size(), 0);
        chk("sel1 busy after frame", {31'd0, busy}, 32'd0);

        // Message 3 with out_ready toggling
        push_frame(0, 3, 16, 2);
        base = acc0;
        toggle_en = 1'b1;
        pulse_load(3'd3);
        wait_done(k);
        toggle_en = 1'b0;
        chk("sel3 done seen", {31'd0, k != 0}, 32'd1);
        chk("sel3 accepted beats", acc0 - base, 34);
        repeat (3) @(negedge clk);

        // Requests while busy: 5 overwritten by 6
        push_frame(0, 2, 16, 2);
        push_frame(0, 6, 16, 2);
        pulse_load(3'd2);
        repeat (5) @(posedge clk);
        pulse_load(3'd5);
        repeat (3) @(posedge clk);
        pulse_load(3'd6);
        wait_done(k);
        chk("sel2 done seen", {31'd0, k != 0}, 32'd1);
        wait_done(k);
        chk("pending frame back-to-back done", k, 35);
        repeat (3) @(negedge clk);
        chk("pending queue drained", q0.size(), 0);
        chk("busy after pending frame", {31'd0, busy}, 32'd0);

        // Auto update: 6 -> 0 (blank frame), then 0 -> 4 without load
        push_frame(0, 0, 16, 2);
        @(posedge clk);
        #1;
        msg_sel = 3'd0;
        wait_done(k);
        chk("auto sel0 done seen", {31'd0, k != 0}, 32'd1);
        repeat (3) @(negedge clk);
        push_frame(0, 4, 16, 2);
        @(posedge clk);
        #1;
        msg_sel = 3'd4;
        @(negedge clk);
        chk("auto start cycle out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("auto next cycle out_valid", {31'd0, out_valid}, 32'd1);
        chk("auto first beat cmd", {23'd0, out_is_cmd, out_data}, {23'd0, 9'h180});
        wait_done(k);
        chk("auto sel4 done cycle", k, 34);
        busy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("no retrigger holding sel4", busy_cnt, 0);
        chk("auto queue drained", q0.size(), 0);

        // 20x4 instance, message 5
        push_frame(4, 5, 20, 4);
        @(posedge clk);
        #1;
        msg_sel4  = 3'd5;
        msg_load4 = 1'b1;
        @(posedge clk);
        #1;
        msg_load4 = 1'b0;
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (done4) begin
                k = i;
                break;
            end
        end
        chk("dut4 done seen", {31'd0, k != 0}, 32'd1);
        chk("dut4 accepted beats", acc4, 84);
        chk("dut4 queue drained", q4.size(), 0);
        @(negedge clk);
        chk("dut4 busy after frame", {31'd0, busy4}, 32'd0);

        // Reset at beat 10 of a frame
        push_frame(0, 1, 16, 2);
        base = acc0;
        pulse_load(3'd1);
        for (int i = 0; i < 100; i++) begin
            if (acc0 - base >= 10) break;
            @(negedge clk);
        end
        chk("beats before reset", acc0 - base, 10);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset out_data", {24'd0, out_data}, 32'h00);
        q0.delete();
        msg_sel = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy || out_valid) busy_cnt++;
        end
        chk("no beats after reset release", busy_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
